csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Machine-mode CSR storage for the riscv32i core. Responds to the CSR port pair driven by the
//  execute/writeback path (write_csr/csrReg_write_dest_reg*/csrReg_read_src_reg*).
//  Maintains the trap state (mstatus, mepc, mcause, mtval) and the 64-bit cycle/instret counters.
//  Supplies the trap vector and return PC to the fetch/PC logic.
// PARAMETERS
//  MHARTID      0             value returned for mhartid (0xF14)
//  MTVEC_RESET  32'h0000_0000 mtvec value after reset; bits[1:0] forced 0
//  MISA_VAL     32'h4000_0100 value returned for misa (RV32I), read-only
// PORTS
//  clk                        in   1   clock, all state updates on posedge
//  reset                      in   1   synchronous, active-high
//  write_csr                  in   1   CSR write strobe
//  csrReg_write_dest_reg      in   12  CSR write address
//  csrReg_write_dest_reg_data in   32  CSR write data (full word; RS/RC merge done upstream)
//  csrReg_read_src_reg        in   12  CSR read address
//  csrReg_read_src_reg_data   out  32  CSR read data, combinational
//  illegal_csr                out  1   read address unsupported, combinational
//  instr_retired              in   1   one instruction retired this cycle
//  trap_valid                 in   1   take trap this cycle
//  trap_pc                    in   32  PC of trapping instruction
//  trap_cause                 in   32  mcause value to record
//  trap_tval                  in   32  mtval value to record
//  mret                       in   1   mret executed this cycle
//  trap_vector                out  32  current mtvec (direct mode), combinational
//  mepc_out                   out  32  current mepc, combinational
//  mie_global                 out  1   mstatus.MIE
// BEHAVIOUR
//  - Interface: one clock, clk; reset is synchronous and active-high, port name reset.
//  - Reset: all CSRs 0, mtvec=MTVEC_RESET&~3, counters 0.
//    Outputs after reset: trap_vector=MTVEC_RESET&~3, mepc_out=0, mie_global=0.
//  - Map (RW unless noted):
//    mstatus 0x300: MIE[3], MPIE[7] stored; MPP[12:11] reads 2'b11; other bits read 0.
//    misa 0x301 RO; mie 0x304; mtvec 0x305 ([1:0] read 0); mscratch 0x340.
//    mepc 0x341 ([1:0] read 0); mcause 0x342; mtval 0x343; mip 0x344 RO 0.
//    mcycle 0xB00 / mcycleh 0xB80; minstret 0xB02 / minstreth 0xB82.
//    cycle 0xC00/0xC80 and instret 0xC02/0xC82 are RO shadows; mhartid 0xF14 RO.
//  - Read: combinational, zero latency.
//    Unmapped address -> data 0 and illegal_csr=1; mapped -> illegal_csr=0.
//  - Read bypass: if write_csr and the write address equals the read address for a writable CSR,
//    read data = write data with that CSR's field masks applied (same-cycle write visible).
//  - Write: takes effect at the next posedge. Writes to RO or unmapped addresses are ignored silently.
//  - Counters: mcycle increments by 1 every non-reset cycle; minstret increments when instr_retired.
//    Both are 64-bit and wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
//    Low-word carry propagates into the high word in the same cycle.
//  - Counter write vs increment: a write to either half replaces that half, and the whole counter
//    does not increment that cycle (write wins).
//  - Trap (trap_valid=1) updates at the next posedge:
//    mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0.
//  - mret (mret=1, trap_valid=0): MIE<=MPIE, MPIE<=1.
//  - Simultaneous events:
//    trap_valid+mret -> trap only.
//    trap_valid + write_csr to mstatus/mepc/mcause/mtval -> trap wins for that CSR; writes to
//    other CSRs still commit.
//    mret + write_csr to mstatus -> mret wins.
//  - Reset asserted mid-operation overrides all writes, traps and increments that cycle.
// CONFIGURATION
//  CSR_COUNTERS_EN defined:
//    mcycle/minstret logic and 0xB00/0xB80/0xB02/0xB82/0xC00/0xC80/0xC02/0xC82 implemented as above.
//  CSR_COUNTERS_EN undefined:
//    those addresses read 0 with illegal_csr=0, writes ignored, no counter flops;
//    instr_retired unused.
// TESTING
//  1 Reset, then read 0x305 -> MTVEC_RESET&~3; read 0x300 -> 32'h0000_1800; read 0x7C0 -> 0, illegal_csr=1.
//  2 Write 0x340=32'hDEAD_BEEF with read addr 0x340 the same cycle -> read DEAD_BEEF the same cycle
//    (bypass) and on the next cycle.
//  3 Write mstatus=32'h8, then trap_valid pc=32'h103, cause=2, tval=32'h13 ->
//    mepc=32'h100, mcause=2, mtval=32'h13, mstatus=32'h1880, mie_global=0;
//    then mret -> mstatus=32'h1888.
//  4 trap_valid with mret and write mepc=32'h400, all in the same cycle -> mepc=trap_pc&~3;
//    mret has no effect.
//  5 [CSR_COUNTERS_EN] write mcycle=32'hFFFF_FFFF, mcycleh=0; next cycle mcycleh=1, mcycle=0;
//    write minstret=5 while instr_retired=1 -> 5, not 6.
//  6 [no CSR_COUNTERS_EN] read 0xB00 after 100 cycles -> 0, illegal_csr=0.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file for the riscv32i core: trap state, mtvec/mscratch/mie storage, 64-bit counters.
// Optional macro CSR_COUNTERS_EN implements mcycle/minstret and their user-mode shadows.
module csr_file #(
  parameter logic [31:0] MHARTID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_csr,
  input  logic [11:0] csrReg_write_dest_reg,
  input  logic [31:0] csrReg_write_dest_reg_data,
  input  logic [11:0] csrReg_read_src_reg,
  output logic [31:0] csrReg_read_src_reg_data,
  output logic        illegal_csr,
  input  logic        instr_retired,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        mie_global
);

  logic        mstatus_mie_reg, mstatus_mie_next;
  logic        mstatus_mpie_reg, mstatus_mpie_next;
  logic [31:0] mie_csr_reg, mie_csr_next;
  logic [31:0] mtvec_reg, mtvec_next;
  logic [31:0] mscratch_reg, mscratch_next;
  logic [31:0] mepc_reg, mepc_next;
  logic [31:0] mcause_reg, mcause_next;
  logic [31:0] mtval_reg, mtval_next;

  logic [11:0] wa;
  logic [31:0] wd;
  logic [31:0] wr_masked;
  logic        wr_writable;
  logic [31:0] rd_data;
  logic        rd_illegal;

  assign wa = csrReg_write_dest_reg;
  assign wd = csrReg_write_dest_reg_data;

  // Write data as it would read back once stored; shared by the bypass path.
  always_comb begin
    wr_masked   = 32'd0;
    wr_writable = 1'b0;
    case (wa)
      12'h300: begin
        wr_masked   = {19'b0, 2'b11, 3'b0, wd[7], 3'b0, wd[3], 3'b0};
        wr_writable = 1'b1;
      end
      12'h304, 12'h340, 12'h342, 12'h343: begin
        wr_masked   = wd;
        wr_writable = 1'b1;
      end
      12'h305, 12'h341: begin
        wr_masked   = {wd[31:2], 2'b00};
        wr_writable = 1'b1;
      end
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82: begin
        wr_masked   = wd;
        wr_writable = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Trap is applied last so it overrides both mret and software writes.
  always_comb begin
    mstatus_mie_next  = mstatus_mie_reg;
    mstatus_mpie_next = mstatus_mpie_reg;
    mie_csr_next      = mie_csr_reg;
    mtvec_next        = mtvec_reg;
    mscratch_next     = mscratch_reg;
    mepc_next         = mepc_reg;
    mcause_next       = mcause_reg;
    mtval_next        = mtval_reg;
    if (write_csr) begin
      case (wa)
        12'h300: begin
          mstatus_mie_next  = wd[3];
          mstatus_mpie_next = wd[7];
        end
        12'h304: mie_csr_next  = wd;
        12'h305: mtvec_next    = {wd[31:2], 2'b00};
        12'h340: mscratch_next = wd;
        12'h341: mepc_next     = {wd[31:2], 2'b00};
        12'h342: mcause_next   = wd;
        12'h343: mtval_next    = wd;
        default: ;
      endcase
    end
    if (mret) begin
      mstatus_mie_next  = mstatus_mpie_reg;
      mstatus_mpie_next = 1'b1;
    end
    if (trap_valid) begin
      mepc_next         = {trap_pc[31:2], 2'b00};
      mcause_next       = trap_cause;
      mtval_next        = trap_tval;
      mstatus_mpie_next = mstatus_mie_reg;
      mstatus_mie_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_csr_reg      <= 32'd0;
      mtvec_reg        <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_reg     <= 32'd0;
      mepc_reg         <= 32'd0;
      mcause_reg       <= 32'd0;
      mtval_reg        <= 32'd0;
    end else begin
      mstatus_mie_reg  <= mstatus_mie_next;
      mstatus_mpie_reg <= mstatus_mpie_next;
      mie_csr_reg      <= mie_csr_next;
      mtvec_reg        <= mtvec_next;
      mscratch_reg     <= mscratch_next;
      mepc_reg         <= mepc_next;
      mcause_reg       <= mcause_next;
      mtval_reg        <= mtval_next;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_reg, mcycle_next;
  logic [63:0] minstret_reg, minstret_next;

  // A write to either half freezes the whole counter for that cycle.
  always_comb begin
    mcycle_next   = mcycle_reg + 64'd1;
    minstret_next = instret_inc(minstret_reg, instr_retired);
    if (write_csr) begin
      case (wa)
        12'hB00: mcycle_next   = {mcycle_reg[63:32], wd};
        12'hB80: mcycle_next   = {wd, mcycle_reg[31:0]};
        12'hB02: minstret_next = {minstret_reg[63:32], wd};
        12'hB82: minstret_next = {wd, minstret_reg[31:0]};
        default: ;
      endcase
    end
  end

  function automatic logic [63:0] instret_inc(input logic [63:0] v, input logic en);
    return en ? v + 64'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_reg   <= 64'd0;
      minstret_reg <= 64'd0;
    end else begin
      mcycle_reg   <= mcycle_next;
      minstret_reg <= minstret_next;
    end
  end
`else
  logic unused_instr_retired;
  assign unused_instr_retired = instr_retired;
`endif

  always_comb begin
    rd_data    = 32'd0;
    rd_illegal = 1'b0;
    case (csrReg_read_src_reg)
      12'h300: rd_data = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};
      12'h301: rd_data = MISA_VAL;
      12'h304: rd_data = mie_csr_reg;
      12'h305: rd_data = mtvec_reg;
      12'h340: rd_data = mscratch_reg;
      12'h341: rd_data = mepc_reg;
      12'h342: rd_data = mcause_reg;
      12'h343: rd_data = mtval_reg;
      12'h344: rd_data = 32'd0;
      12'hF14: rd_data = MHARTID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: rd_data = mcycle_reg[31:0];
      12'hB80, 12'hC80: rd_data = mcycle_reg[63:32];
      12'hB02, 12'hC02: rd_data = minstret_reg[31:0];
      12'hB82, 12'hC82: rd_data = minstret_reg[63:32];
`else
      12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: rd_data = 32'd0;
`endif
      default: rd_illegal = 1'b1;
    endcase
    if (write_csr && wr_writable && (wa == csrReg_read_src_reg))
      rd_data = wr_masked;
  end

  assign csrReg_read_src_reg_data = rd_data;
  assign illegal_csr              = rd_illegal;
  assign trap_vector              = mtvec_reg;
  assign mepc_out                 = mepc_reg;
  assign mie_global               = mstatus_mie_reg;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus queues expected outputs, a negedge monitor pops and compares.
// Checks counters when built with CSR_COUNTERS_EN, otherwise checks the counter addresses read as 0.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_csr;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        illegal;
  logic        instr_retired;
  logic        trap_valid;
  logic [31:0] trap_pc, trap_cause, trap_tval;
  logic        mret;
  logic [31:0] trap_vector, mepc_out;
  logic        mie_global;

  always #5 clk = ~clk;

  csr_file #(.MHARTID(32'd5), .MTVEC_RESET(32'h0000_1003), .MISA_VAL(32'h4000_0100)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .write_csr                  (write_csr),
    .csrReg_write_dest_reg      (wr_addr),
    .csrReg_write_dest_reg_data (wr_data),
    .csrReg_read_src_reg        (rd_addr),
    .csrReg_read_src_reg_data   (rd_data),
    .illegal_csr                (illegal),
    .instr_retired              (instr_retired),
    .trap_valid                 (trap_valid),
    .trap_pc                    (trap_pc),
    .trap_cause                 (trap_cause),
    .trap_tval                  (trap_tval),
    .mret                       (mret),
    .trap_vector                (trap_vector),
    .mepc_out                   (mepc_out),
    .mie_global                 (mie_global)
  );

  // kind: 0 read port (data+illegal), 1 trap_vector, 2 mepc_out, 3 mie_global
  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] d;
    logic        ill;
  } item_t;

  item_t sb[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t it;
      logic [31:0] act;
      logic        act_ill;
      it      = sb.pop_front();
      act_ill = 1'b0;
      case (it.kind)
        0:       begin act = rd_data; act_ill = illegal; end
        1:       act = trap_vector;
        2:       act = mepc_out;
        default: act = {31'd0, mie_global};
      endcase
      total++;
      if (act !== it.d || act_ill !== it.ill) begin
        bad++;
        $display("FAIL %s: got data=%h illegal=%b, want data=%h illegal=%b",
                 it.nm, act, act_ill, it.d, it.ill);
      end else
        $display("ok   %s: data=%h illegal=%b", it.nm, act, act_ill);
    end
  end

  task automatic exp_rd(input string nm, input logic [11:0] a, input logic [31:0] d, input logic ill);
    item_t it;
    rd_addr = a;
    it.nm = nm; it.kind = 0; it.d = d; it.ill = ill;
    sb.push_back(it);
  endtask

  task automatic exp_out(input string nm, input int kind, input logic [31:0] d);
    item_t it;
    it.nm = nm; it.kind = kind; it.d = d; it.ill = 1'b0;
    sb.push_back(it);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    write_csr = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
    trap_valid = 1'b1; trap_pc = pc; trap_cause = cause; trap_tval = tval;
  endtask

  // Advance one cycle; inputs return to idle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    write_csr = 1'b0; trap_valid = 1'b0; mret = 1'b0; instr_retired = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write_csr = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    instr_retired = 1'b0; trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; trap_tval = '0;
    mret = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    exp_rd("rst_mtvec", 12'h305, 32'h0000_1000, 1'b0);
    exp_out("rst_trap_vector", 1, 32'h0000_1000);
    exp_out("rst_mepc_out", 2, 32'h0);
    exp_out("rst_mie_global", 3, 32'h0);
    tick();
    exp_rd("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0); tick();
    exp_rd("unmapped_7c0", 12'h7C0, 32'h0, 1'b1); tick();
    exp_rd("misa", 12'h301, 32'h4000_0100, 1'b0); tick();
    wr(12'h301, 32'hFFFF_FFFF);
    exp_rd("mhartid", 12'hF14, 32'd5, 1'b0); tick();
    exp_rd("misa_ro_after_write", 12'h301, 32'h4000_0100, 1'b0); tick();
    exp_rd("mip_zero", 12'h344, 32'h0, 1'b0); tick();

    // Bypass and masking
    wr(12'h340, 32'hDEAD_BEEF);
    exp_rd("mscratch_bypass", 12'h340, 32'hDEAD_BEEF, 1'b0); tick();
    exp_rd("mscratch_stored", 12'h340, 32'hDEAD_BEEF, 1'b0); tick();
    wr(12'h305, 32'h0000_1237);
    exp_rd("mtvec_bypass_mask", 12'h305, 32'h0000_1234, 1'b0); tick();
    exp_rd("mtvec_stored", 12'h305, 32'h0000_1234, 1'b0);
    exp_out("trap_vector_new", 1, 32'h0000_1234); tick();
    wr(12'h304, 32'h0000_0ABC); tick();
    exp_rd("mie_csr", 12'h304, 32'h0000_0ABC, 1'b0); tick();

    // Trap then mret
    wr(12'h300, 32'h0000_0008);
    exp_rd("mstatus_bypass", 12'h300, 32'h0000_1808, 1'b0); tick();
    trap(32'h103, 32'd2, 32'h13);
    exp_rd("mstatus_pre_trap", 12'h300, 32'h0000_1808, 1'b0);
    exp_out("mie_global_pre_trap", 3, 32'h1); tick();
    exp_rd("mepc_after_trap", 12'h341, 32'h100, 1'b0);
    exp_out("mepc_out_after_trap", 2, 32'h100);
    exp_out("mie_global_after_trap", 3, 32'h0); tick();
    exp_rd("mcause_after_trap", 12'h342, 32'd2, 1'b0); tick();
    exp_rd("mtval_after_trap", 12'h343, 32'h13, 1'b0); tick();
    mret = 1'b1;
    exp_rd("mstatus_after_trap", 12'h300, 32'h0000_1880, 1'b0); tick();
    exp_rd("mstatus_after_mret", 12'h300, 32'h0000_1888, 1'b0);
    exp_out("mie_global_after_mret", 3, 32'h1); tick();

    // Trap + mret + mepc write in one cycle: trap wins everywhere
    trap(32'h207, 32'd7, 32'h55); mret = 1'b1; wr(12'h341, 32'h400); tick();
    exp_rd("mepc_trap_wins", 12'h341, 32'h204, 1'b0);
    exp_out("mepc_out_trap_wins", 2, 32'h204); tick();
    exp_rd("mstatus_mret_ignored", 12'h300, 32'h0000_1880, 1'b0); tick();

    // Trap plus write to an unrelated CSR: both commit
    trap(32'h300, 32'd3, 32'h0); wr(12'h340, 32'h0000_1111); tick();
    exp_rd("mscratch_with_trap", 12'h340, 32'h0000_1111, 1'b0);
    exp_out("mepc_out_second_trap", 2, 32'h300); tick();
    exp_rd("mstatus_second_trap", 12'h300, 32'h0000_1800, 1'b0); tick();

    // mret beats a same-cycle mstatus write
    mret = 1'b1; wr(12'h300, 32'h0000_0088); tick();
    exp_rd("mstatus_mret_wins", 12'h300, 32'h0000_1880, 1'b0); tick();

`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 32'hFFFF_FFFF);
    exp_rd("mcycle_bypass", 12'hB00, 32'hFFFF_FFFF, 1'b0); tick();
    wr(12'hB80, 32'h0); tick();
    exp_rd("mcycleh_before_carry", 12'hB80, 32'h0, 1'b0); tick();
    exp_rd("mcycleh_carry", 12'hB80, 32'h1, 1'b0); tick();
    exp_rd("mcycle_low_after_carry", 12'hB00, 32'h1, 1'b0); tick();
    wr(12'hB02, 32'd5); instr_retired = 1'b1; tick();
    exp_rd("minstret_write_wins", 12'hB02, 32'd5, 1'b0); tick();
    instr_retired = 1'b1; tick();
    exp_rd("instret_shadow", 12'hC02, 32'd6, 1'b0); tick();
`else
    repeat (100) tick();
    exp_rd("mcycle_disabled", 12'hB00, 32'h0, 1'b0); tick();
    wr(12'hB00, 32'h1234); tick();
    exp_rd("mcycle_write_ignored", 12'hB00, 32'h0, 1'b0); tick();
    exp_rd("cycleh_disabled", 12'hC80, 32'h0, 1'b0); tick();
`endif

    tick();
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
